// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the write, read, issue and scoreboard signals of reg_file_sb.
//   wen/waddr/wdata    : writeback port
//   raddr1/raddr2      : read indices
//   rdata1/rdata2      : combinational read data
//   iss_valid/iss_rd   : issue of an instruction with destination iss_rd
//   busy1/busy2        : pending-write flag for each read index
//   busy_vec           : registered per-register pending-write flags
// master: drives writeback/read/issue requests (pipeline side)
// slave : the register file itself
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                       wen;
    logic [ADDR_WIDTH-1:0]      waddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [ADDR_WIDTH-1:0]      raddr1;
    logic [ADDR_WIDTH-1:0]      raddr2;
    logic [DATA_WIDTH-1:0]      rdata1;
    logic [DATA_WIDTH-1:0]      rdata2;
    logic                       iss_valid;
    logic [ADDR_WIDTH-1:0]      iss_rd;
    logic                       busy1;
    logic                       busy2;
    logic [(2**ADDR_WIDTH)-1:0] busy_vec;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2, iss_valid, iss_rd,
        input  rdata1, rdata2, busy1, busy2, busy_vec
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2, iss_valid, iss_rd,
        output rdata1, rdata2, busy1, busy2, busy_vec
    );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Register file (one write port, two read ports) with an integrated
// pending-write scoreboard.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset, clears storage and scoreboard
//   rf    : reg_file_sb_if.slave bundle (writeback, reads, issue, busy)
// Parameters:
//   ADDR_WIDTH : register index width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH : register width
//   ZERO_REG   : 1 -> register 0 reads zero, ignores writes, never busy
//   BYPASS     : 1 -> same-cycle writeback data is forwarded to reads
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_next;

    function automatic logic is_hardzero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A read hits the writeback port when forwarding is enabled and the
    // index is a real register being written this cycle.
    function automatic logic fwd_hit(input logic                  w_en,
                                     input logic [ADDR_WIDTH-1:0] w_addr,
                                     input logic [ADDR_WIDTH-1:0] r_addr);
        return (BYPASS != 0) && w_en && (w_addr == r_addr) && !is_hardzero(r_addr);
    endfunction

    // Issue is applied after writeback so a new producer to the same index
    // wins over the retiring one.
    always_comb begin
        busy_next = busy_q;
        if (rf.wen)
            busy_next[rf.waddr] = 1'b0;
        if (rf.iss_valid && !is_hardzero(rf.iss_rd))
            busy_next[rf.iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            busy_q <= '0;
        end else begin
            if (rf.wen && !is_hardzero(rf.waddr))
                mem[rf.waddr] <= rf.wdata;
            busy_q <= busy_next;
        end
    end

    // Outputs are forced low during reset so nothing is forwarded while the
    // write port is being ignored.
    always_comb begin
        rf.rdata1 = '0;
        rf.busy1  = 1'b0;
        if (reset && !is_hardzero(rf.raddr1)) begin
            if (fwd_hit(rf.wen, rf.waddr, rf.raddr1)) begin
                rf.rdata1 = rf.wdata;
            end else begin
                rf.rdata1 = mem[rf.raddr1];
                rf.busy1  = busy_q[rf.raddr1];
            end
        end
    end

    always_comb begin
        rf.rdata2 = '0;
        rf.busy2  = 1'b0;
        if (reset && !is_hardzero(rf.raddr2)) begin
            if (fwd_hit(rf.wen, rf.waddr, rf.raddr2)) begin
                rf.rdata2 = rf.wdata;
            end else begin
                rf.rdata2 = mem[rf.raddr2];
                rf.busy2  = busy_q[rf.raddr2];
            end
        end
    end

    assign rf.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. Three instances share clk/reset:
//   dut_a : 5x32, ZERO_REG=1, BYPASS=1
//   dut_b : 5x32, ZERO_REG=1, BYPASS=0
//   dut_c : 4x64, ZERO_REG=0, BYPASS=1
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    reg_file_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) ifa ();
    reg_file_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) ifb ();
    reg_file_sb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64)) ifc ();

    reg_file_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .reset(reset), .rf(ifa.slave));
    reg_file_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clk(clk), .reset(reset), .rf(ifb.slave));
    reg_file_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .ZERO_REG(0), .BYPASS(1))
        dut_c (.clk(clk), .reset(reset), .rf(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge, well away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        ifa.wen = 0; ifa.waddr = '0; ifa.wdata = '0; ifa.raddr1 = '0; ifa.raddr2 = '0;
        ifa.iss_valid = 0; ifa.iss_rd = '0;
        ifb.wen = 0; ifb.waddr = '0; ifb.wdata = '0; ifb.raddr1 = '0; ifb.raddr2 = '0;
        ifb.iss_valid = 0; ifb.iss_rd = '0;
        ifc.wen = 0; ifc.waddr = '0; ifc.wdata = '0; ifc.raddr1 = '0; ifc.raddr2 = '0;
        ifc.iss_valid = 0; ifc.iss_rd = '0;
    endtask

    function automatic logic [63:0] cval(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_all();

        // Reset state
        #1;
        chk("rst_rdata1_a", 64'(ifa.rdata1), 64'h0);
        chk("rst_busyvec_a", 64'(ifa.busy_vec), 64'h0);
        chk("rst_busyvec_c", 64'(ifc.busy_vec), 64'h0);
        #20 reset = 1'b1;   // released mid-cycle
        step();

        // Write r5 then read it back unbypassed
        ifa.wen = 1; ifa.waddr = 5; ifa.wdata = 32'hDEAD_BEEF;
        step();
        ifa.wen = 0; ifa.raddr1 = 5;
        #1;
        chk("r5_rdata1", 64'(ifa.rdata1), 64'hDEAD_BEEF);
        chk("r5_busy1", 64'(ifa.busy1), 64'h0);

        // Write r0 is discarded
        ifa.wen = 1; ifa.waddr = 0; ifa.wdata = 32'h1234_5678; ifa.raddr1 = 0;
        #1;
        chk("r0_same_cycle", 64'(ifa.rdata1), 64'h0);
        step();
        ifa.wen = 0;
        #1;
        chk("r0_next_cycle", 64'(ifa.rdata1), 64'h0);
        chk("r0_busyvec0", 64'(ifa.busy_vec[0]), 64'h0);
        // Issue to r0 is ignored
        ifa.iss_valid = 1; ifa.iss_rd = 0;
        step();
        ifa.iss_valid = 0;
        #1;
        chk("r0_issue_busy", 64'(ifa.busy_vec[0]), 64'h0);

        // Forwarding vs no forwarding: r7 = 1, then write 0xAA while reading
        ifa.wen = 1; ifa.waddr = 7; ifa.wdata = 32'h1;
        ifb.wen = 1; ifb.waddr = 7; ifb.wdata = 32'h1;
        step();
        ifa.wdata = 32'hAA; ifa.raddr2 = 7;
        ifb.wdata = 32'hAA; ifb.raddr2 = 7;
        #1;
        chk("bypass_on_rdata2", 64'(ifa.rdata2), 64'hAA);
        chk("bypass_off_rdata2", 64'(ifb.rdata2), 64'h1);
        step();
        ifa.wen = 0; ifb.wen = 0;
        #1;
        chk("bypass_off_after", 64'(ifb.rdata2), 64'hAA);

        // Scoreboard: issue r3, collide, then retire
        ifa.iss_valid = 1; ifa.iss_rd = 3;
        step();
        ifa.iss_valid = 0; ifa.raddr1 = 3;
        #1;
        chk("sb_r3_set", 64'(ifa.busy_vec[3]), 64'h1);
        chk("sb_busy1_r3", 64'(ifa.busy1), 64'h1);
        ifa.wen = 1; ifa.waddr = 3; ifa.wdata = 32'h33;
        ifa.iss_valid = 1; ifa.iss_rd = 3;
        #1;
        chk("sb_busy1_fwd", 64'(ifa.busy1), 64'h0);
        chk("sb_rdata1_fwd", 64'(ifa.rdata1), 64'h33);
        step();
        ifa.wen = 0; ifa.iss_valid = 0;
        #1;
        chk("sb_r3_newprod", 64'(ifa.busy_vec[3]), 64'h1);
        chk("sb_r3_data", 64'(ifa.rdata1), 64'h33);
        ifa.wen = 1; ifa.waddr = 3; ifa.wdata = 32'h34;
        step();
        ifa.wen = 0;
        #1;
        chk("sb_r3_clear", 64'(ifa.busy_vec[3]), 64'h0);
        chk("sb_r3_data2", 64'(ifa.rdata1), 64'h34);

        // Different indices in the same cycle both apply
        ifa.iss_valid = 1; ifa.iss_rd = 4;
        step();
        ifa.iss_rd = 6; ifa.wen = 1; ifa.waddr = 4; ifa.wdata = 32'h44;
        step();
        ifa.iss_valid = 0; ifa.wen = 0;
        #1;
        chk("sb_diff_vec", 64'(ifa.busy_vec), 64'h0000_0040);
        // Re-issue busy r6, write non-busy r8
        ifa.iss_valid = 1; ifa.iss_rd = 6; ifa.wen = 1; ifa.waddr = 8; ifa.wdata = 32'h88;
        step();
        ifa.iss_valid = 0; ifa.wen = 0; ifa.raddr2 = 8;
        #1;
        chk("sb_reissue_vec", 64'(ifa.busy_vec), 64'h0000_0040);
        chk("sb_nonbusy_data", 64'(ifa.rdata2), 64'h88);
        ifa.wen = 1; ifa.waddr = 6; ifa.wdata = 32'h66;
        step();
        ifa.wen = 0;
        #1;
        chk("sb_single_retire", 64'(ifa.busy_vec), 64'h0);

        // Without forwarding the busy flag stays up during writeback
        ifb.iss_valid = 1; ifb.iss_rd = 10;
        step();
        ifb.iss_valid = 0; ifb.wen = 1; ifb.waddr = 10; ifb.wdata = 32'hA0; ifb.raddr1 = 10;
        #1;
        chk("nobyp_busy1", 64'(ifb.busy1), 64'h1);
        chk("nobyp_rdata1", 64'(ifb.rdata1), 64'h0);
        step();
        ifb.wen = 0;
        #1;
        chk("nobyp_after", 64'(ifb.busy1), 64'h0);

        // Asynchronous reset between edges
        ifa.iss_valid = 1; ifa.iss_rd = 9; ifa.wen = 1; ifa.waddr = 9; ifa.wdata = 32'h55;
        step();
        ifa.iss_valid = 0; ifa.wen = 0; ifa.raddr1 = 9; ifa.raddr2 = 5;
        #1;
        chk("pre_rst_rdata1", 64'(ifa.rdata1), 64'h55);
        chk("pre_rst_busy9", 64'(ifa.busy_vec[9]), 64'h1);
        #1 reset = 1'b0;
        #1;
        chk("arst_rdata1", 64'(ifa.rdata1), 64'h0);
        chk("arst_rdata2", 64'(ifa.rdata2), 64'h0);
        chk("arst_busyvec", 64'(ifa.busy_vec), 64'h0);
        // Writes and issues ignored during reset, no forwarding
        ifa.wen = 1; ifa.waddr = 5; ifa.wdata = 32'hFF; ifa.raddr1 = 5;
        ifa.iss_valid = 1; ifa.iss_rd = 12;
        #1;
        chk("rst_nobypass", 64'(ifa.rdata1), 64'h0);
        step();
        ifa.wen = 0; ifa.iss_valid = 0;
        #1;
        chk("rst_edge_busy", 64'(ifa.busy_vec), 64'h0);
        reset = 1'b1;
        #1;
        chk("post_rst_r5", 64'(ifa.rdata1), 64'h0);
        step();

        // 4x64, ordinary r0: fill all 16 entries and read back on both ports
        for (int i = 0; i < 16; i++) begin
            ifc.wen = 1; ifc.waddr = 4'(i); ifc.wdata = cval(i);
            step();
        end
        ifc.wen = 0;
        for (int i = 0; i < 16; i++) begin
            ifc.raddr1 = 4'(i); ifc.raddr2 = 4'(15 - i);
            #1;
            chk($sformatf("c_p1_r%0d", i), ifc.rdata1, cval(i));
            chk($sformatf("c_p2_r%0d", 15 - i), ifc.rdata2, cval(15 - i));
        end
        chk("c_busyvec", 64'(ifc.busy_vec), 64'h0);
        // Register 0 is ordinary here, so it can become busy
        ifc.iss_valid = 1; ifc.iss_rd = 0;
        step();
        ifc.iss_valid = 0; ifc.raddr1 = 0; ifc.raddr2 = 0;
        #1;
        chk("c_r0_busyvec", 64'(ifc.busy_vec), 64'h1);
        chk("c_r0_busy1", 64'(ifc.busy1), 64'h1);
        chk("c_r0_same_p2", ifc.rdata2, cval(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
